triangle_sequencer: RTL and testbench
=====================================

// Module: triangle_sequencer
// PURPOSE
//  Controller that sequences a triangle-wave generator. It drives the generator's enable at a
//  programmable rate, clears it at start, and counts completed periods by watching its output.
//  It runs a programmed number of periods or runs continuously, and stops only at zero.
//  A start/busy/done handshake lets a top-level FSM or button logic launch bursts.
// PARAMETERS
//  N      8   width of generator output tri_out
//  DIV_W  16  width of rate divider div
//  CNT_W  8   width of period count; periods==0 means continuous
// PORTS
//  clk           in   1      system clock; all logic on posedge
//  rst           in   1      asynchronous, active-low reset
//  start         in   1      level-sampled launch request; ignored unless IDLE
//  stop          in   1      level-sampled graceful-stop request; ignored in IDLE/DONE
//  div           in   DIV_W  ena period minus one; latched at start
//  periods       in   CNT_W  periods to run; latched at start; 0 = run until stop
//  tri_out       in   N      current generator value (registered in generator)
//  tri_ena       out  1      one-cycle enable pulse to generator
//  tri_clr       out  1      synchronous clear to generator (active-high)
//  busy          out  1      high in CLEAR, RUN, PARK
//  done          out  1      one-cycle pulse on sequence completion
//  periods_done  out  CNT_W  completed periods this run; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, tri_ena=0, tri_clr=0, busy=0, done=0,
//   periods_done=0, tick counter=0, div_q=0, per_q=0, was_nz=0.
//  States (state_t): IDLE, CLEAR, RUN, PARK, DONE.
//  - IDLE: start=1 at edge k -> latch div_q/per_q, periods_done=0 -> CLEAR for cycle k+1.
//  - CLEAR: tri_clr=1 for exactly one cycle, was_nz<=0, tick<=0.
//      stop=1 -> DONE; else -> RUN.
//  - RUN: tick counts 0..div_q; tri_ena=1 (combinational from tick) when tick==div_q,
//      then tick<=0. div_q=0 gives ena every cycle. The first ena is in cycle k+2+div_q.
//  - Period complete (RUN or PARK): tri_out==0 && was_nz==1.
//      was_nz<=(tri_out!=0) every cycle outside IDLE.
//      On completion: periods_done<=periods_done+1, saturating.
//  - RUN exits:
//      per_q!=0 and completion brings periods_done to per_q -> DONE (takes priority over stop).
//      Otherwise stop=1 -> PARK, evaluated after the completion count.
//  - PARK: keep ticking as in RUN until tri_out==0, then DONE. If tri_out==0 already on
//      entry, DONE next cycle. Further stop/start are ignored.
//  - DONE: done=1 for one cycle, tri_ena=0, busy=0 -> IDLE.
//      periods_done holds its value until the next start.
//  - Simultaneous start+stop in IDLE: start wins; stop is ignored.
//  - Divider and period count arithmetic are unsigned. The tick compare is equality only.
//  - div/periods changes during a run have no effect, because both are latched at start.
//  - Reset mid-run: immediate IDLE with outputs at reset values. No done pulse.
//      The generator's own reset is separate.
// STRUCTURE
//  - Package tri_seq_pkg: typedef enum logic [2:0] state_t {IDLE,CLEAR,RUN,PARK,DONE}.
//  - Sub-module tick_divider #(DIV_W): ports clk, rst, clr, run, div -> tick pulse.
//      clr zeroes it; it holds when run=0.
//  - Top: FSM (always_ff + always_comb next-state), period counter, was_nz flag.
// TESTING
//  1. Async reset asserted mid-RUN (div=3) -> same-cycle tri_ena=0, busy=0, periods_done=0;
//     no done pulse.
//  2. div=0, periods=1, generator attached, start 1 cycle -> tri_clr at k+1, ena every cycle
//     from k+2; done pulses once when tri_out returns to 0; periods_done=1.
//  3. div=4, periods=2 -> tri_ena spacing exactly 5 cycles; done after 2nd return-to-zero;
//     periods_done=2.
//  4. periods=0, stop asserted while tri_out=37 -> PARK; ena continues until tri_out==0;
//     done 1 cycle later; busy low.
//  5. start held high through a whole run, plus start+stop together in IDLE -> exactly one
//     run per IDLE entry; stop ignored in IDLE.
//  6. stop in CLEAR -> DONE next cycle; periods_done=0; no tri_ena pulse ever.

Source files
------------

// File: rtl/tri_seq_pkg.sv
// Shared types and default widths for the triangle-wave sequencer.
package tri_seq_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned DIV_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        PARK,
        DONE
    } state_t;

endpackage

// File: rtl/tick_divider.sv
// Rate divider: tick is high on every (div+1)-th cycle while run is high.
module tick_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             at_div;

    assign at_div = (cnt == div);
    assign tick   = run && at_div;

    // Counter wraps on equality only; div is held constant for the whole run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= at_div ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/triangle_sequencer.sv
// Sequences a triangle-wave generator: clears it, paces its enable, counts
// completed periods and ends after a programmed count or a graceful stop.
module triangle_sequencer
    import tri_seq_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] periods,
    input  logic [N-1:0]     tri_out,
    output logic             tri_ena,
    output logic             tri_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] periods_done
);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] per_q;
    logic             was_nz;
    logic             tri_zero;
    logic             active;
    logic             period_end;
    logic [CNT_W-1:0] pd_inc;
    logic             target_hit;

    assign tri_zero   = (tri_out == '0);
    assign active     = (state == RUN) || (state == PARK);
    assign period_end = active && tri_zero && was_nz;
    assign pd_inc     = (periods_done == '1) ? periods_done : periods_done + CNT_W'(1);
    assign target_hit = period_end && (per_q != '0) && (pd_inc == per_q);

    tick_divider #(
        .DIV_W(DIV_W)
    ) u_tick_divider (
        .clk (clk),
        .rst (rst),
        .clr (state == CLEAR),
        .run (active),
        .div (div_q),
        .tick(tri_ena)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reaching the programmed count beats a concurrent stop request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = stop ? DONE : RUN;
            RUN: begin
                if (target_hit) begin
                    state_nxt = DONE;
                end else if (stop) begin
                    state_nxt = PARK;
                end
            end
            PARK:    if (tri_zero) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tri_clr <= (state_nxt == CLEAR);
            busy    <= (state_nxt inside {CLEAR, RUN, PARK});
            done    <= (state_nxt == DONE);
        end
    end

    // Run parameters, period counter and the "generator has left zero" flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            per_q        <= '0;
            periods_done <= '0;
            was_nz       <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                div_q        <= div;
                per_q        <= periods;
                periods_done <= '0;
            end else if (period_end) begin
                periods_done <= pd_inc;
            end

            if (state == CLEAR) begin
                was_nz <= 1'b0;
            end else if (state != IDLE) begin
                was_nz <= !tri_zero;
            end
        end
    end

endmodule

// File: tb/tb_triangle_sequencer.sv
// Bench for triangle_sequencer with an attached behavioural triangle generator.
module tb_triangle_sequencer;

    localparam int unsigned N     = 8;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 8;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             start   = 1'b0;
    logic             stop    = 1'b0;
    logic [DIV_W-1:0] div     = '0;
    logic [CNT_W-1:0] periods = '0;
    logic [N-1:0]     tri_out;
    logic             tri_ena;
    logic             tri_clr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] periods_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int peak   = 2;

    logic [N-1:0] gen = '0;
    logic         up  = 1'b1;

    int ena_q[$];
    int clr_q[$];
    int done_q[$];

    typedef struct {
        int d;
        int p;
        int pk;
        int off;
        int enas;
        int pd;
    } vec_t;

    vec_t vecs[4];

    triangle_sequencer #(
        .N    (N),
        .DIV_W(DIV_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .div         (div),
        .periods     (periods),
        .tri_out     (tri_out),
        .tri_ena     (tri_ena),
        .tri_clr     (tri_clr),
        .busy        (busy),
        .done        (done),
        .periods_done(periods_done)
    );

    assign tri_out = gen;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Triangle generator: 0 up to peak, back down to 0, repeat.
    always @(posedge clk) begin
        if (tri_clr) begin
            gen <= '0;
            up  <= 1'b1;
        end else if (tri_ena) begin
            if (up) begin
                gen <= gen + N'(1);
                if (int'(gen) + 1 >= peak) up <= 1'b0;
            end else begin
                gen <= gen - N'(1);
                if (gen == N'(1)) up <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (tri_ena) ena_q.push_back(cyc);
        if (tri_clr) clr_q.push_back(cyc);
        if (done)    done_q.push_back(cyc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Closed-form timeline of an uninterrupted run, relative to the CLEAR cycle.
    function automatic int exp_off(input int d, input int p, input int pk);
        return 3 + d + (2 * pk * p - 1) * (d + 1);
    endfunction

    function automatic int exp_enas(input int d, input int p, input int pk);
        return (d == 0) ? 2 * pk * p + 1 : 2 * pk * p;
    endfunction

    task automatic launch(input int d, input int p, output int s);
        div     = DIV_W'(d);
        periods = CNT_W'(p);
        start   = 1'b1;
        step();
        start   = 1'b0;
        s       = cyc;
        div     = DIV_W'($urandom);
        periods = CNT_W'($urandom);
    endtask

    task automatic wait_done(input int budget, input string tag, output int dc);
        dc = -1;
        for (int i = 0; i < budget && dc < 0; i++) begin
            if (done) dc = cyc;
            else step();
        end
        if (dc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout: got no done within %0d cycles", tag, budget);
        end
    endtask

    task automatic run_check(input string tag, input int d, input int p, input int pk,
                             input int off, input int enas, input int pd);
        int s;
        int dc;
        int base;
        int bad;
        peak = pk;
        base = ena_q.size();
        launch(d, p, s);
        chk({tag, "/clr"}, int'(tri_clr), 1);
        chk({tag, "/busy"}, int'(busy), 1);
        wait_done(5000, tag, dc);
        chk({tag, "/done_off"}, dc - s, off);
        chk({tag, "/enas"}, ena_q.size() - base, enas);
        chk({tag, "/pd"}, int'(periods_done), pd);
        bad = 0;
        for (int i = base; i < ena_q.size(); i++)
            if (ena_q[i] != s + 1 + d + (i - base) * (d + 1)) bad++;
        chk({tag, "/ena_timing"}, bad, 0);
        step();
        chk({tag, "/busy_after"}, int'(busy), 0);
        chk({tag, "/done_width"}, int'(done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        int dc;
        int c;
        int found;
        int base;
        int cbase;
        int dbase;
        int d;
        int p;
        int pk;

        vecs[0] = '{d: 0, p: 1, pk: 2, off: 6,  enas: 5, pd: 1};
        vecs[1] = '{d: 4, p: 2, pk: 2, off: 42, enas: 8, pd: 2};
        vecs[2] = '{d: 1, p: 1, pk: 3, off: 14, enas: 6, pd: 1};
        vecs[3] = '{d: 2, p: 3, pk: 1, off: 20, enas: 6, pd: 3};

        // Reset values
        step();
        step();
        chk("rst/ena", int'(tri_ena), 0);
        chk("rst/clr", int'(tri_clr), 0);
        chk("rst/busy", int'(busy), 0);
        chk("rst/done", int'(done), 0);
        chk("rst/pd", int'(periods_done), 0);
        rst = 1'b1;
        step();

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].pk,
                      vecs[i].off, vecs[i].enas, vecs[i].pd);

        for (int i = 0; i < 8; i++) begin
            d  = $urandom_range(0, 3);
            p  = $urandom_range(1, 3);
            pk = $urandom_range(1, 4);
            run_check($sformatf("rnd%0d", i), d, p, pk, exp_off(d, p, pk), exp_enas(d, p, pk), p);
        end

        // Async reset in the middle of a continuous run with div=3
        peak = 1;
        launch(3, 0, s);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (periods_done != '0 && tri_ena) found = 1;
        end
        chk("mrst/setup", found, 1);
        dbase = done_q.size();
        #1;
        rst = 1'b0;
        #1;
        chk("mrst/ena", int'(tri_ena), 0);
        chk("mrst/busy", int'(busy), 0);
        chk("mrst/pd", int'(periods_done), 0);
        chk("mrst/clr", int'(tri_clr), 0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mrst/no_done", done_q.size() - dbase, 0);
        chk("mrst/idle", int'(busy), 0);

        // Continuous run, stop while generator reads 37
        peak = 40;
        launch(0, 0, s);
        cbase = clr_q.size();
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (tri_out == N'(37)) found = 1;
        end
        chk("park/setup", found, 1);
        stop = 1'b1;
        c    = cyc;
        base = ena_q.size();
        step();
        stop = 1'b0;
        chk("park/busy", int'(busy), 1);
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(300, "park", dc);
        chk("park/done_off", dc - c, 44);
        chk("park/enas", ena_q.size() - base, 43);
        chk("park/pd", int'(periods_done), 1);
        chk("park/no_relaunch", clr_q.size() - cbase, 0);
        step();
        chk("park/busy_after", int'(busy), 0);

        // Start held through two runs; start+stop together in IDLE
        peak    = 1;
        cbase   = clr_q.size();
        dbase   = done_q.size();
        div     = DIV_W'(1);
        periods = CNT_W'(1);
        start   = 1'b1;
        stop    = 1'b1;
        step();
        stop = 1'b0;
        s    = cyc;
        chk("hold/clr", int'(tri_clr), 1);
        wait_done(100, "hold1", dc);
        chk("hold/done1_off", dc - s, 6);
        step();
        wait_done(100, "hold2", dc);
        chk("hold/done2_off", dc - s, 14);
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("hold/clr_cnt", clr_q.size() - cbase, 2);
        chk("hold/clr2_at", clr_q[clr_q.size() - 1] - s, 8);
        stop = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stop = 1'b0;
        chk("hold/idle_stop_busy", int'(busy), 0);
        chk("hold/done_cnt", done_q.size() - dbase, 2);

        // Stop during CLEAR
        peak  = 3;
        base  = ena_q.size();
        launch(2, 2, s);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("clrstop/done", int'(done), 1);
        chk("clrstop/pd", int'(periods_done), 0);
        for (int i = 0; i < 5; i++) step();
        chk("clrstop/enas", ena_q.size() - base, 0);
        chk("clrstop/busy", int'(busy), 0);

        // Period counter saturation in continuous mode
        peak = 1;
        launch(0, 0, s);
        found = 0;
        for (int i = 0; i < 1500 && found == 0; i++) begin
            step();
            if (periods_done == '1) found = 1;
        end
        chk("sat/reach", found, 1);
        for (int i = 0; i < 20; i++) step();
        chk("sat/hold", int'(periods_done), 255);
        chk("sat/busy", int'(busy), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(50, "sat", dc);
        chk("sat/final", int'(periods_done), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
